elink_frame_rx: RTL
===================

ELINK_FRAME_RX -- requirements
Module: elink_frame_rx

Interface
REQ-001 SHALL have parameter SOF_PATTERN, default 8'h3C, start-of-frame marker.
REQ-002 SHALL have parameter EOF_PATTERN, default 8'hDC, end-of-frame marker.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_elink2bit  input  2  e-link dibit from the MOPSHUB downlink serializer, MSB-first.
REQ-006 SHALL have port rx_en  input  1  dibit strobe; a dibit is consumed only when rx_en=1.
REQ-007 SHALL have port data_rec_76bit  output  76  last good frame payload.
REQ-008 SHALL have port data_valid  output  1  payload available, held until acknowledged.
REQ-009 SHALL have port data_ack  input  1  consumer acknowledge; clears data_valid.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse, bad EOF.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse, good frame dropped because data_valid still set.
REQ-012 SHALL have port frame_cnt  output  16  count of accepted frames, wraps.
REQ-013 SHALL have port err_cnt  output  8  count of frame_err events, saturates at 255.
REQ-014 SHALL have port busy  output  1  high in PAYLOAD or EOF state.

Function
REQ-015 SHALL implement states HUNT, PAYLOAD, EOF; only strobed dibits (rx_en=1) advance shifts, counters or state.
REQ-016 HUNT: SHALL shift each dibit into an 8-bit window (new dibit into bits[1:0]); when the window including the current dibit equals SOF_PATTERN, go to PAYLOAD with dibit counter=0 next cycle.
REQ-017 PAYLOAD: SHALL shift 38 dibits MSB-first into a 76-bit staging register; after the 38th (counter=37) go to EOF with counter cleared.
REQ-018 EOF: SHALL collect 4 dibits; after the 4th, compare to EOF_PATTERN and return to HUNT with window cleared to 8'h00.
REQ-019 EOF match with data_valid=0 or data_ack=1 in the same cycle: SHALL load data_rec_76bit from staging, set data_valid, increment frame_cnt, all on the following edge (latency 1 cycle after last EOF dibit).
REQ-020 EOF match with data_valid=1 and data_ack=0: SHALL drop the frame, keep data_rec_76bit, pulse overflow one cycle, not increment frame_cnt.
REQ-021 EOF mismatch: SHALL pulse frame_err one cycle, increment err_cnt unless 255, leave data outputs unchanged.
REQ-022 data_ack with data_valid=1 and no simultaneous load: SHALL clear data_valid next edge; data_ack with data_valid=0 SHALL be ignored.
REQ-023 SOF patterns appearing inside PAYLOAD or EOF SHALL be treated as data (no resync mid-frame).
REQ-024 data_rec_76bit SHALL be stable while data_valid=1 except on a load per REQ-019.
REQ-025 frame_cnt SHALL wrap 16'hFFFF->16'h0000.

Reset
REQ-026 On rst=0, asynchronously: state=HUNT, window, staging, counter=0, data_rec_76bit=76'h0, data_valid=0, frame_err=0, overflow=0, frame_cnt=0, err_cnt=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL hunt for a fresh SOF.

Verification
REQ-028 Idle 00 dibits, then SOF 3C, payload 76'h123456789ABCDEF0123, EOF DC, rx_en=1 always -> data_valid=1 one cycle after last EOF dibit, data_rec_76bit=76'h123456789ABCDEF0123, frame_cnt=1.
REQ-029 Same frame with EOF 8'hDD -> frame_err pulse 1 cycle, err_cnt=1, data_valid stays 0, frame_cnt=0.
REQ-030 Two good frames back-to-back, data_ack never asserted -> first payload retained, overflow pulse once, frame_cnt=1; repeat with data_ack coincident to second EOF -> second payload loaded, frame_cnt=2, no overflow.
REQ-031 rx_en toggling 1/0 every cycle during a good frame -> identical payload result, completion after 2x the strobed-cycle count.
REQ-032 rst=0 pulsed after 20 payload dibits, then a full good frame -> only the second frame reported, frame_cnt=1, no frame_err.
REQ-033 256 bad-EOF frames -> err_cnt=255 saturated, 256 frame_err pulses observed.

Source files
------------

// File: rtl/elink_frame_rx.sv
// E-link downlink frame receiver: hunts for an SOF byte, captures a 76-bit
// payload, checks the EOF byte and hands accepted frames to the consumer.
module elink_frame_rx #(
  parameter logic [7:0] SOF_PATTERN = 8'h3C,
  parameter logic [7:0] EOF_PATTERN = 8'hDC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rx_elink2bit,
  input  logic        rx_en,
  output logic [75:0] data_rec_76bit,
  output logic        data_valid,
  input  logic        data_ack,
  output logic        frame_err,
  output logic        overflow,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {S_HUNT, S_PAYLOAD, S_EOF} state_e;

  state_e      state_q, state_d;
  // Last three dibits; with the current dibit they form the 8-bit window.
  logic [5:0]  hist_q, hist_d;
  logic [75:0] stage_q, stage_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [75:0] data_q, data_d;
  logic        dv_q, dv_d;
  logic        ferr_q, ferr_d;
  logic        ovf_q, ovf_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [7:0]  window;
  logic        load;

  assign window = {hist_q, rx_elink2bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_HUNT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_en) begin
      case (state_q)
        S_HUNT:    if (window == SOF_PATTERN) state_d = S_PAYLOAD;
        S_PAYLOAD: if (cnt_q == 6'd37)        state_d = S_EOF;
        S_EOF:     if (cnt_q == 6'd3)         state_d = S_HUNT;
        default:                              state_d = S_HUNT;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != S_HUNT);
  end

  always_comb begin
    hist_d  = hist_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dv_d    = dv_q;
    ferr_d  = 1'b0;
    ovf_d   = 1'b0;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    load    = 1'b0;
    if (rx_en) begin
      case (state_q)
        S_HUNT: begin
          hist_d = window[5:0];
          cnt_d  = 6'd0;
        end
        S_PAYLOAD: begin
          stage_d = {stage_q[73:0], rx_elink2bit};
          cnt_d   = (cnt_q == 6'd37) ? 6'd0 : cnt_q + 6'd1;
        end
        S_EOF: begin
          // The EOF byte reuses the window history; four shifts replace it fully.
          hist_d = window[5:0];
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd3) begin
            cnt_d  = 6'd0;
            hist_d = 6'd0;
            if (window == EOF_PATTERN) begin
              if (!dv_q || data_ack) begin
                load   = 1'b1;
                data_d = stage_q;
                fcnt_d = fcnt_q + 16'd1;
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
              if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
    // A load in the same cycle as an ack keeps the new frame valid.
    if (load)                  dv_d = 1'b1;
    else if (data_ack && dv_q) dv_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      hist_q  <= hist_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign data_rec_76bit = data_q;
  assign data_valid     = dv_q;
  assign frame_err      = ferr_q;
  assign overflow       = ovf_q;
  assign frame_cnt      = fcnt_q;
  assign err_cnt        = ecnt_q;

endmodule
